// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, keyboard command bytes and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK     = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad plus falling-edge strobe; resets to the idle-high line level.
// Latency: level 2 cycles after the pad, fall strobe on the same cycle level drops.
// Backpressure: none, free-running.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= pad;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-bit shift, ACK check.
// Latency: INHIBIT_CYC cycles plus the device's clocking; done/error pulse on the return to IDLE.
// Backpressure: tx_start is dropped while busy; nothing is queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750_000
) (
    input  logic       clk,
    input  logic       rstin,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYC);
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYC - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    if (CLK_HZ == 0 || INHIBIT_CYC < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("ps2_host_tx: CLK_HZ must be nonzero and cycle counts at least 2");
    end

    ps2_tx_state_t    state;
    logic [7:0]       tx_byte;
    logic             parity;
    logic [3:0]       edge_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             clk_lvl;
    logic             clk_fall;
    logic             dat_lvl;
    logic             dat_fall_unused;
    logic             timeout;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (rstin),
        .pad   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (clk),
        .rst_n (rstin),
        .pad   (ps2_data_in),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

    assign busy    = (state != IDLE);
    assign timeout = (state != IDLE) && (state != INHIBIT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_byte     <= '0;
            parity      <= 1'b0;
            edge_cnt    <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (state != IDLE && state != INHIBIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // Timeout outranks every in-flight transition so done/error stay exclusive.
            if (timeout) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_error    <= 1'b1;
                state       <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tx_start) begin
                            tx_byte    <= tx_data;
                            parity     <= odd_parity(tx_data);
                            edge_cnt   <= '0;
                            inh_cnt    <= '0;
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_DATA) begin
                            ps2_data_oe <= 1'b1;
                        end
                        if (inh_cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            to_cnt     <= '0;
                            state      <= REQ;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    REQ: begin
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            case (edge_cnt)
                                4'd0, 4'd1, 4'd2, 4'd3,
                                4'd4, 4'd5, 4'd6, 4'd7: ps2_data_oe <= ~tx_byte[edge_cnt[2:0]];
                                4'd8:                   ps2_data_oe <= ~parity;
                                default: begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ACK;
                                end
                            endcase
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            if (!dat_lvl) begin
                                state <= WAIT_IDLE;
                            end else begin
                                tx_error <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_lvl && dat_lvl) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model clocking at 60 us;
// expected frame bits and outcomes are queued at tx_start and consumed as the device samples.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int  CLK_HZ  = 500_000;
    localparam int  INH     = 50;
    localparam int  TO      = 7500;
    localparam time CLK_PER = 2000;
    localparam time HALF    = 30_000;

    logic       clk = 1'b0;
    logic       rstin = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    int n_checks = 0;
    int n_fail = 0;

    logic exp_bits[$];
    int   exp_res[$];

    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   inh_run = 0;
    int   inh_len = 0;
    int   inh_overlap = 0;
    int   inh_starts = 0;
    int   req_cyc = 0;
    int   err_cyc = 0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #(CLK_PER / 2) clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rstin       (rstin),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    // Output monitor: inhibit length, REQ entry cycle and pulse counts.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ps2_clk_oe) begin
            if (!prev_clk_oe) begin
                inh_run     = 0;
                inh_overlap = 0;
                inh_starts  = inh_starts + 1;
            end
            inh_run = inh_run + 1;
            if (ps2_data_oe) inh_overlap = inh_overlap + 1;
        end else if (prev_clk_oe) begin
            inh_len = inh_run;
            if (ps2_data_oe) req_cyc = cyc;
        end
        prev_clk_oe = ps2_clk_oe;
        if (tx_done) done_cnt = done_cnt + 1;
        if (tx_error) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (tx_done && tx_error) both_cnt = both_cnt + 1;
    end

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_bits.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device model: waits for request-to-send, clocks 11 edges, samples bits on rising edges.
    task automatic dev_run(input bit ack_low, input int last_edge, input int poke);
        logic got;
        logic exp;
        for (int i = 0; i < INH + 50 && !ps2_clk_oe; i++) @(negedge clk);
        for (int i = 0; i < INH + 50 && ps2_clk_oe; i++) @(negedge clk);
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL dev_req: clk_oe=%b data_oe=%b required clk_oe=0 data_oe=1", ps2_clk_oe, ps2_data_oe);
            return;
        end
        #(HALF);
        for (int n = 1; n <= 11; n++) begin
            dev_clk_low = 1'b1;
            if (n == poke) begin
                @(negedge clk);
                @(negedge clk);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
            if (n == last_edge) return;
            #(HALF);
            dev_clk_low = 1'b0;
            if (n <= 10) begin
                got = ~(ps2_data_oe | dev_data_low);
                n_checks++;
                if (exp_bits.size() == 0) begin
                    n_fail++;
                    $display("FAIL bit%0d: got %b but no bit expected", n, got);
                end else begin
                    exp = exp_bits.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL bit%0d: got %b required %b", n, got, exp);
                    end
                end
            end
            #(HALF / 2);
            if (n == 10) dev_data_low = ack_low;
            #(HALF / 2);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset;
        #(CLK_PER * 3 + 100);
        n_checks++; if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL rst_clk_oe: got %b required 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe: got %b required 0", ps2_data_oe); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (tx_done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b required 0", tx_done); end
        n_checks++; if (tx_error !== 1'b0)    begin n_fail++; $display("FAIL rst_error: got %b required 0", tx_error); end
        @(negedge clk);
        rstin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input bit ack_low, input int poke);
        int d0, e0, s0, exp_err;
        d0 = done_cnt; e0 = err_cnt; s0 = inh_starts;
        push_frame(b);
        exp_res.push_back(ack_low ? 0 : 1);
        send(b);
        dev_run(ack_low, 0, poke);
        for (int i = 0; i < 400 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        exp_err = exp_res.pop_front();
        n_checks++; if (inh_len !== INH)      begin n_fail++; $display("FAIL %s inhibit_len: got %0d required %0d", name, inh_len, INH); end
        n_checks++; if (inh_overlap !== 1)    begin n_fail++; $display("FAIL %s data_oe_in_inhibit: got %0d cycles required 1", name, inh_overlap); end
        n_checks++; if (done_cnt - d0 !== 1 - exp_err) begin n_fail++; $display("FAIL %s done_pulses: got %0d required %0d", name, done_cnt - d0, 1 - exp_err); end
        n_checks++; if (err_cnt - e0 !== exp_err)      begin n_fail++; $display("FAIL %s error_pulses: got %0d required %0d", name, err_cnt - e0, exp_err); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL %s busy_after: got %b required 0", name, busy); end
        n_checks++; if (inh_starts - s0 !== 1) begin n_fail++; $display("FAIL %s transactions: got %0d required 1", name, inh_starts - s0); end
        n_checks++; if (exp_bits.size() !== 0) begin n_fail++; $display("FAIL %s bits_left: got %0d required 0", name, exp_bits.size()); end
    endtask

    task automatic test_silent_device;
        int d0, e0, exp_err;
        d0 = done_cnt; e0 = err_cnt;
        exp_res.push_back(1);
        send(CMD_RESET);
        for (int i = 0; i < INH + 20 && ps2_clk_oe; i++) @(negedge clk);
        for (int i = 0; i < TO + 100; i++) begin
            @(negedge clk);
            if (tx_error) break;
        end
        #1;
        exp_err = exp_res.pop_front();
        n_checks++; if (tx_error !== 1'b1)    begin n_fail++; $display("FAIL silent_error: got %b required 1", tx_error); end
        n_checks++; if (err_cyc - req_cyc !== TO) begin n_fail++; $display("FAIL silent_timeout: got %0d cycles required %0d", err_cyc - req_cyc, TO); end
        n_checks++; if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL silent_clk_oe: got %b required 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL silent_data_oe: got %b required 0", ps2_data_oe); end
        @(negedge clk);
        n_checks++; if (tx_error !== 1'b0)    begin n_fail++; $display("FAIL silent_pulse_width: got %b required 0", tx_error); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL silent_busy: got %b required 0", busy); end
        n_checks++; if (err_cnt - e0 !== exp_err) begin n_fail++; $display("FAIL silent_error_count: got %0d required %0d", err_cnt - e0, exp_err); end
        n_checks++; if (done_cnt - d0 !== 0)  begin n_fail++; $display("FAIL silent_done: got %0d required 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        push_frame(CMD_SET_LED);
        send(CMD_SET_LED);
        dev_run(1'b1, 5, 0);
        repeat (4) @(negedge clk);
        n_checks++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_bit5_drive: got %b required 1", ps2_data_oe); end
        #100;
        rstin = 1'b0;
        #1;
        n_checks++; if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL midrst_clk_oe: got %b required 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_data_oe: got %b required 0", ps2_data_oe); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
        dev_clk_low = 1'b0;
        exp_bits.delete();
        repeat (3) @(negedge clk);
        rstin = 1'b1;
        repeat (3) @(negedge clk);
        test_frame("after_reset", CMD_ENABLE, 1'b1, 0);
    endtask

    task automatic test_exclusive_pulses;
        n_checks++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_and_error_same_cycle: got %0d cycles required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_frame("set_led", CMD_SET_LED, 1'b1, 0);
        test_frame("enable", CMD_ENABLE, 1'b1, 0);
        test_frame("missing_ack", CMD_RESET, 1'b0, 0);
        test_silent_device;
        test_reset_mid;
        test_frame("start_during_shift", CMD_SET_LED, 1'b1, 3);
        test_exclusive_pulses;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000: system clock frequency in Hz.
REQ-002 The block SHALL have parameter INHIBIT_CYC, default 5000: clock-low request hold, 100 us at 50 MHz.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 750_000: transaction abort limit, 15 ms at 50 MHz.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstin, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tx_start, input, 1 bit: one-cycle request to send tx_data.
REQ-007 The block SHALL have port tx_data, input, 8 bits: command byte to the keyboard (e.g. 0xED set LEDs, 0xF4 enable).
REQ-008 The block SHALL have port ps2_clk_in, input, 1 bit: PS2_CLK pad level, asynchronous to clk.
REQ-009 The block SHALL have port ps2_data_in, input, 1 bit: DATA_PS2 pad level, asynchronous to clk.
REQ-010 The block SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls PS2_CLK low; 0 releases it (open-drain).
REQ-011 The block SHALL have port ps2_data_oe, output, 1 bit: 1 pulls DATA_PS2 low; 0 releases it.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE; used to gate the keyboard receiver.
REQ-013 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse when the device acknowledges the byte.
REQ-014 The block SHALL have port tx_error, output, 1 bit: one-cycle pulse on missing ACK or timeout.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL each pass through a 2-FF synchronizer. A falling edge SHALL be detected as synchronized previous=1, current=0.
REQ-016 The FSM states SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-017 In IDLE, tx_start SHALL latch tx_data, compute the odd-parity bit (~^tx_data), clear the edge counter, and go to INHIBIT.
REQ-018 INHIBIT SHALL assert ps2_clk_oe for exactly INHIBIT_CYC cycles. ps2_data_oe SHALL rise in its final cycle.
REQ-019 REQ SHALL release ps2_clk_oe and hold ps2_data_oe=1 (start bit 0), then go to SHIFT in the next cycle.
REQ-020 In SHIFT, on each device falling edge n (n = 1..10), ps2_data_oe SHALL be set as follows:
- n = 1..8: ~data[n-1], LSB first.
- n = 9: ~parity.
- n = 10: 0, releasing the line as the stop bit.
After edge 10 the FSM SHALL go to ACK.
REQ-021 ACK SHALL sample synchronized data on falling edge 11.
- Data low: go to WAIT_IDLE.
- Data high: pulse tx_error, then go to IDLE.
REQ-022 WAIT_IDLE SHALL wait until both synchronized lines read 1, then pulse tx_done and go to IDLE.
REQ-023 A cycle counter SHALL start on REQ entry. Reaching TIMEOUT_CYC in REQ, SHIFT, ACK or WAIT_IDLE SHALL release both lines, pulse tx_error, and go to IDLE.
REQ-024 tx_start SHALL be ignored while busy=1. No queueing is performed.
REQ-025 tx_done and tx_error SHALL never assert in the same cycle. Each pulse SHALL coincide with the return to IDLE, with busy=0 from the next cycle.
REQ-026 A device falling edge outside SHIFT/ACK SHALL have no effect.

Reset
REQ-027 While rstin=0, the block SHALL hold the state in IDLE and drive ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0.
REQ-028 Reset asserted mid-transaction SHALL release both lines immediately (asynchronously). The synchronizers SHALL reset to 1.
REQ-029 The latched byte and all counters SHALL clear to 0.

Structure
REQ-030 A shared package ps2_pkg SHALL hold:
- the state enum;
- command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
- PS2_ACK=8'hFA.
REQ-031 The synchronizer plus falling-edge detector SHALL be one sub-module, ps2_sync_edge. The block SHALL instantiate it twice, and the receiver SHALL reuse it.
REQ-032 Counter widths SHALL be $clog2 of the corresponding parameter.

Verification
REQ-033 Scenario tx_data=0xED: the bench SHALL use a device model clocking at a 60 us period and driving ACK low on edge 11. It SHALL check all of:
- clk held low for INHIBIT_CYC cycles;
- sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
- tx_done pulses once;
- tx_error stays 0.
REQ-034 Scenario tx_data=0xF4: the bench SHALL check bits 0,0,1,0,1,1,1,1 and parity 0.
REQ-035 Scenario missing ACK: the device leaves data high on edge 11. The bench SHALL check that tx_error pulses once, tx_done stays 0, and busy falls.
REQ-036 Scenario silent device: no clocks are generated. The bench SHALL check that tx_error pulses TIMEOUT_CYC cycles after REQ entry and both oe outputs are 0.
REQ-037 Scenario rstin low at edge 5: the bench SHALL check that both oe outputs go to 0 within the same cycle, busy=0, and a new tx_start after reset sends a correct frame.
REQ-038 Scenario tx_start pulsed during SHIFT: the bench SHALL check that the current frame is unchanged and no second transaction starts.
